// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes
// and the datapath select codes understood by the datapath and ALU decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12,
        S_UPPER    = 4'd13,
        S_TRAP     = 4'd14
    } mc_state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // First state after DECODE for a given opcode.
    function automatic mc_state_t decode_target(input logic [6:0] op, input logic trap_on_illegal);
        mc_state_t nxt;
        case (op)
            OP_LW, OP_SW:     nxt = S_MEMADR;
            OP_R:             nxt = S_EXECUTER;
            OP_I:             nxt = S_EXECUTEI;
            OP_BR:            nxt = S_BRANCH;
            OP_JAL:           nxt = S_JAL;
            OP_JALR:          nxt = S_JALR1;
            OP_LUI, OP_AUIPC: nxt = S_UPPER;
            default:          nxt = trap_on_illegal ? S_TRAP : S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/imm_srcdec.sv
// Opcode to immediate-format decoder; purely combinational, independent of FSM state.
module imm_srcdec
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:            imm_src = IMM_S;
            OP_BR:            imm_src = IMM_B;
            OP_JAL:           imm_src = IMM_J;
            OP_LUI, OP_AUIPC: imm_src = IMM_U;
            default:          imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv


// File: rtl/mc_mainfsm.sv
// Multi-cycle main control FSM: steps each instruction through its states and
// drives datapath enables/selects, with a mem_ready handshake on memory states.
//
// state      | meaning
// FETCH      | read instruction at PC, PC+4 -> PC on mem_ready
// DECODE     | OldPC+imm precomputed, dispatch on op
// MEMADR     | RD1+imm address for lw/sw
// MEMREAD    | load access, wait mem_ready
// MEMWB      | load data -> register file
// MEMWRITE   | store access, write on mem_ready
// EXECUTER   | RD1 op RD2
// EXECUTEI   | RD1 op imm
// ALUWB      | ALUOut -> register file
// BRANCH     | compare, target from DECODE
// JAL        | target -> PC, OldPC+4 for link
// JALR1      | RD1+imm target
// JALR2      | target -> PC, OldPC+4 for link
// UPPER      | lui (0+imm) / auipc (OldPC+imm)
// TRAP       | illegal opcode, held until reset
module mc_mainfsm
    import mc_ctrl_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       illegal,
    output logic [3:0] state_o
);

    mc_state_t state_q, state_d;
    logic      mem_req_en, pc_update_en, branch_en, reg_write_en, mem_write_en, ir_write_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        mem_req_en   = 1'b0;
        pc_update_en = 1'b0;
        branch_en    = 1'b0;
        reg_write_en = 1'b0;
        mem_write_en = 1'b0;
        ir_write_en  = 1'b0;
        AdrSrc       = 1'b0;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RD2;
        ResultSrc    = RES_ALUOUT;
        ALUOp        = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_en   = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                ir_write_en  = mem_ready;
                pc_update_en = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                state_d = decode_target(op, TRAP_ON_ILLEGAL);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_en = 1'b1;
                AdrSrc     = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc    = RES_DATA;
                reg_write_en = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_en   = 1'b1;
                AdrSrc       = 1'b1;
                mem_write_en = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_en = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RD1;
                ALUOp     = ALUOP_BRANCH;
                branch_en = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL, S_JALR2: begin
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_FOUR;
                pc_update_en = 1'b1;
                state_d      = S_ALUWB;
            end
            S_JALR1: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_d = S_JALR2;
            end
            S_UPPER: begin
                // lui has op[5]=1 and adds imm to zero; auipc adds it to OldPC
                ALUSrcA = op[5] ? SRCA_ZERO : SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are gated by rst_n so an access in flight is abandoned the instant reset lands.
    assign mem_req  = mem_req_en & rst_n;
    assign PCUpdate = pc_update_en & rst_n;
    assign Branch   = branch_en & rst_n;
    assign RegWrite = reg_write_en & rst_n;
    assign MemWrite = mem_write_en & rst_n;
    assign IRWrite  = ir_write_en & rst_n;
    assign illegal  = (state_q == S_TRAP);
    assign state_o  = state_q;

    imm_srcdec u_imm_srcdec (
        .op      (op),
        .imm_src (ImmSrc)
    );

endmodule

// File: tb/tb_mc_mainfsm.sv
// Bench for mc_mainfsm: directed sequences with literal expectations, then random
// ops/mem_ready/reset checked against an instruction-as-phase-list model.
module tb_mc_mainfsm;
    import mc_ctrl_pkg::*;

    localparam logic [6:0] T_LW = 7'b0000011, T_SW = 7'b0100011, T_R = 7'b0110011,
                           T_I = 7'b0010011, T_BR = 7'b1100011, T_JAL = 7'b1101111,
                           T_JALR = 7'b1100111, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111,
                           T_BAD = 7'b1111111;

    typedef struct packed {
        logic       mem_req, pc_update, branch, reg_write, mem_write, ir_write, adr_src;
        logic [1:0] src_a, src_b, res_src, alu_op;
        logic [2:0] imm_src;
        logic       illegal;
        logic [3:0] state;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_ready;
    logic [6:0] op1, op0;
    always #5 clk = ~clk;

    logic       mreq1, pcu1, br1, rw1, mw1, irw1, adr1, ill1;
    logic [1:0] sa1, sb1, rs1, ao1;
    logic [2:0] imm1;
    logic [3:0] st1;
    logic       mreq0, pcu0, br0, rw0, mw0, irw0, adr0, ill0;
    logic [1:0] sa0, sb0, rs0, ao0;
    logic [2:0] imm0;
    logic [3:0] st0;
    ctrl_t      act1, act0;

    assign act1 = {mreq1, pcu1, br1, rw1, mw1, irw1, adr1, sa1, sb1, rs1, ao1, imm1, ill1, st1};
    assign act0 = {mreq0, pcu0, br0, rw0, mw0, irw0, adr0, sa0, sb0, rs0, ao0, imm0, ill0, st0};

    mc_mainfsm #(.TRAP_ON_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .op(op1), .mem_ready(mem_ready),
        .mem_req(mreq1), .PCUpdate(pcu1), .Branch(br1), .RegWrite(rw1), .MemWrite(mw1),
        .IRWrite(irw1), .AdrSrc(adr1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ResultSrc(rs1),
        .ALUOp(ao1), .ImmSrc(imm1), .illegal(ill1), .state_o(st1)
    );

    mc_mainfsm #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .op(op0), .mem_ready(mem_ready),
        .mem_req(mreq0), .PCUpdate(pcu0), .Branch(br0), .RegWrite(rw0), .MemWrite(mw0),
        .IRWrite(irw0), .AdrSrc(adr0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ResultSrc(rs0),
        .ALUOp(ao0), .ImmSrc(imm0), .illegal(ill0), .state_o(st0)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int k1 = 0, k0 = 0;   // position within the current instruction's phase list

    // Phase k of the instruction selected by op; past the end it is FETCH again.
    function automatic mc_state_t route_step(input logic [6:0] op, input int k, input bit trap_en);
        mc_state_t r[5];
        int        n;
        r = '{S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH};
        n = 2;
        case (op)
            T_LW:            begin r[2] = S_MEMADR;   r[3] = S_MEMREAD;  r[4] = S_MEMWB; n = 5; end
            T_SW:            begin r[2] = S_MEMADR;   r[3] = S_MEMWRITE; n = 4; end
            T_R:             begin r[2] = S_EXECUTER; r[3] = S_ALUWB;    n = 4; end
            T_I:             begin r[2] = S_EXECUTEI; r[3] = S_ALUWB;    n = 4; end
            T_BR:            begin r[2] = S_BRANCH;   n = 3; end
            T_JAL:           begin r[2] = S_JAL;      r[3] = S_ALUWB;    n = 4; end
            T_JALR:          begin r[2] = S_JALR1;    r[3] = S_JALR2;    r[4] = S_ALUWB; n = 5; end
            T_LUI, T_AUIPC:  begin r[2] = S_UPPER;    r[3] = S_ALUWB;    n = 4; end
            default:         if (trap_en) begin r[2] = S_TRAP; n = 3; end
        endcase
        return (k >= 0 && k < n) ? r[k] : S_FETCH;
    endfunction

    function automatic int adv(input int k, input logic [6:0] op, input logic rst,
                               input logic rdy, input bit trap_en);
        mc_state_t s;
        s = route_step(op, k, trap_en);
        if (!rst) return 0;
        if ((s == S_FETCH || s == S_MEMREAD || s == S_MEMWRITE) && !rdy) return k;
        if (s == S_TRAP) return k;
        if (route_step(op, k + 1, trap_en) == S_FETCH) return 0;
        return k + 1;
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            T_SW:           return 3'b001;
            T_BR:           return 3'b010;
            T_JAL:          return 3'b011;
            T_LUI, T_AUIPC: return 3'b100;
            default:        return 3'b000;
        endcase
    endfunction

    function automatic ctrl_t expect_ctrl(input mc_state_t s, input logic [6:0] op,
                                          input logic rdy, input logic rst);
        ctrl_t c;
        c = '0;
        c.state   = s;
        c.imm_src = imm_of(op);
        case (s)
            S_FETCH:    begin c.mem_req = 1; c.src_b = 2'b10; c.res_src = 2'b10;
                              c.ir_write = rdy; c.pc_update = rdy; end
            S_DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
            S_MEMADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
            S_MEMREAD:  begin c.mem_req = 1; c.adr_src = 1; end
            S_MEMWB:    begin c.res_src = 2'b01; c.reg_write = 1; end
            S_MEMWRITE: begin c.mem_req = 1; c.adr_src = 1; c.mem_write = rdy; end
            S_EXECUTER: begin c.src_a = 2'b10; c.alu_op = 2'b10; end
            S_EXECUTEI: begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b10; end
            S_ALUWB:    c.reg_write = 1;
            S_BRANCH:   begin c.src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1; end
            S_JAL:      begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_update = 1; end
            S_JALR1:    begin c.src_a = 2'b10; c.src_b = 2'b01; end
            S_JALR2:    begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_update = 1; end
            S_UPPER:    begin c.src_a = op[5] ? 2'b11 : 2'b01; c.src_b = 2'b01; end
            S_TRAP:     c.illegal = 1;
            default:    ;
        endcase
        if (!rst) begin
            c.mem_req = 0; c.pc_update = 0; c.branch = 0;
            c.reg_write = 0; c.mem_write = 0; c.ir_write = 0;
        end
        return c;
    endfunction

    task automatic model_check(input string name, input ctrl_t act, input ctrl_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h (state %0d) expected %h (state %0d)",
                     name, cycle, act, act.state, exp, exp.state);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    // One clock: advance the models on the edge, drive inputs on the falling edge
    // (ops only change while the model says FETCH), then compare both DUTs.
    task automatic tick(input logic r, input logic [6:0] o1, input logic [6:0] o0, input logic rdy);
        @(posedge clk);
        k1 = adv(k1, op1, rst_n, mem_ready, 1'b1);
        k0 = adv(k0, op0, rst_n, mem_ready, 1'b0);
        @(negedge clk);
        cycle++;
        rst_n = r;
        if (!r) begin k1 = 0; k0 = 0; end
        if (route_step(op1, k1, 1'b1) == S_FETCH) op1 = o1;
        if (route_step(op0, k0, 1'b0) == S_FETCH) op0 = o0;
        mem_ready = rdy;
        #2;
        model_check("model_trap", act1, expect_ctrl(route_step(op1, k1, 1'b1), op1, mem_ready, rst_n));
        model_check("model_nop",  act0, expect_ctrl(route_step(op0, k0, 1'b0), op0, mem_ready, rst_n));
    endtask

    function automatic logic [6:0] pick_op();
        logic [6:0] tbl [9];
        tbl = '{T_LW, T_SW, T_R, T_I, T_BR, T_JAL, T_JALR, T_LUI, T_AUIPC};
        if ($urandom_range(0, 99) < 12) return 7'($urandom_range(0, 127));
        return tbl[$urandom_range(0, 8)];
    endfunction

    mc_state_t lw_seq [4] = '{S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; op1 = T_R; op0 = T_R;

        for (int i = 0; i < 3; i++) tick(1'b0, T_LW, T_LW, 1'b1);
        lit("reset_state", 32'(act1.state), 32'(S_FETCH));
        lit("reset_enables", {act1.mem_req, act1.ir_write, act1.pc_update, act1.reg_write}, 0);
        lit("reset_illegal", 32'(act1.illegal), 0);

        tick(1'b1, T_LW, T_LW, 1'b1);
        lit("release_irwrite", 32'(act1.ir_write), 1);
        lit("release_pcupdate", 32'(act1.pc_update), 1);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, T_LW, T_LW, 1'b1);
            lit("lw_state", 32'(act1.state), 32'(lw_seq[i]));
        end
        lit("lw_regwrite", 32'(act1.reg_write), 1);
        lit("lw_resultsrc", 32'(act1.res_src), 32'h1);

        tick(1'b1, T_SW, T_SW, 1'b1);
        lit("sw_fetch", 32'(act1.state), 32'(S_FETCH));
        tick(1'b1, T_SW, T_SW, 1'b1);
        tick(1'b1, T_SW, T_SW, 1'b1);
        lit("sw_memadr", 32'(act1.state), 32'(S_MEMADR));
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, T_SW, T_SW, 1'b0);
            lit("sw_wait_state", 32'(act1.state), 32'(S_MEMWRITE));
            lit("sw_wait_memwrite", 32'(act1.mem_write), 0);
        end
        tick(1'b1, T_SW, T_SW, 1'b1);
        lit("sw_memwrite_pulse", 32'(act1.mem_write), 1);
        tick(1'b1, T_JALR, T_JALR, 1'b1);
        lit("sw_done_fetch", 32'(act1.state), 32'(S_FETCH));
        lit("sw_no_second_write", 32'(act1.mem_write), 0);

        tick(1'b1, T_JALR, T_JALR, 1'b1);
        tick(1'b1, T_JALR, T_JALR, 1'b1);
        lit("jalr1", 32'(act1.state), 32'(S_JALR1));
        tick(1'b1, T_JALR, T_JALR, 1'b1);
        lit("jalr2_state", 32'(act1.state), 32'(S_JALR2));
        lit("jalr2_pcupdate", 32'(act1.pc_update), 1);
        lit("jalr2_resultsrc", 32'(act1.res_src), 0);
        tick(1'b1, T_JALR, T_JALR, 1'b1);
        lit("jalr_aluwb_regwrite", 32'(act1.reg_write), 1);

        tick(1'b1, T_BAD, T_BAD, 1'b1);
        lit("jalr_done_fetch", 32'(act1.state), 32'(S_FETCH));
        tick(1'b1, T_BAD, T_BAD, 1'b1);
        tick(1'b1, T_BAD, T_BAD, 1'b1);
        lit("nop_back_to_fetch", 32'(act0.state), 32'(S_FETCH));
        for (int i = 0; i < 10; i++) begin
            lit("trap_state", 32'(act1.state), 32'(S_TRAP));
            lit("trap_illegal", 32'(act1.illegal), 1);
            lit("nop_illegal", 32'(act0.illegal), 0);
            tick(1'b1, T_BAD, T_BAD, 1'b1);
        end

        tick(1'b0, T_LW, T_LW, 1'b1);
        lit("trap_cleared", 32'(act1.illegal), 0);
        for (int i = 0; i < 4; i++) tick(1'b1, T_LW, T_LW, (i < 3) ? 1'b1 : 1'b0);
        lit("midread_state", 32'(act1.state), 32'(S_MEMREAD));
        tick(1'b0, T_LW, T_LW, 1'b0);
        lit("midread_reset_state", 32'(act1.state), 32'(S_FETCH));
        lit("midread_reset_memreq", 32'(act1.mem_req), 0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, T_LW, T_LW, 1'b0);
            lit("midread_no_regwrite", 32'(act1.reg_write), 0);
            lit("midread_refetch", 32'(act1.state), 32'(S_FETCH));
        end

        for (int i = 0; i < 3000; i++)
            tick(($urandom_range(0, 59) != 0), pick_op(), pick_op(), ($urandom_range(0, 9) < 7));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_mainfsm.md
# mc_mainfsm

Multi-cycle main control FSM for the RV32I core, the sequential successor to the single-cycle main decoder. It steps each instruction through fetch/decode/execute/memory/writeback states, driving the shared datapath's enables and mux selects. It adds a memory ready handshake, JALR/LUI/AUIPC support and illegal-opcode handling. It sits between the instruction register (`op`) and the multi-cycle datapath. The ALU decoder stays a separate block, fed by `ALUOp`.

## Interface
- `TRAP_ON_ILLEGAL`, default 1: 1 = an illegal opcode enters sticky TRAP; 0 = an illegal opcode is treated as NOP and the FSM returns to FETCH.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `op` input 7: opcode from the instruction register; stable from DECODE until the next FETCH.
- `mem_ready` input 1: memory completes the current access this cycle.
- `mem_req` output 1: memory access request.
- `PCUpdate`, `Branch`, `RegWrite`, `MemWrite`, `IRWrite` output 1 each: datapath enables.
- `AdrSrc` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `ALUSrcA` output 2: 00 = PC, 01 = OldPC, 10 = RD1, 11 = zero.
- `ALUSrcB` output 2: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `ResultSrc` output 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUOp` output 2: 00 = add, 01 = branch compare, 10 = funct-decoded.
- `ImmSrc` output 3: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U. Combinational from `op`, independent of state.
- `illegal` output 1: sticky trap flag.
- `state_o` output 4: current state, for debug.

## Operation
- Outputs are Moore (decoded from the state register). Exceptions: `IRWrite`, `PCUpdate` in FETCH and `MemWrite` in MEMWRITE are additionally ANDed with `mem_ready`.
- Opcodes handled: 0000011 lw, 0100011 sw, 0110011 R, 0010011 I-ALU, 1100011 branch, 1101111 jal, 1100111 jalr, 0110111 lui, 0010111 auipc.
- State controls and transitions (fields not listed are 0 / 00):
  - FETCH: mem_req, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. IRWrite and PCUpdate fire on mem_ready, which also moves to DECODE; otherwise hold.
  - DECODE: ALUSrcA=01, ALUSrcB=01, computes OldPC+imm. Next state by op: lw/sw→MEMADR; R→EXECUTER; I→EXECUTEI; branch→BRANCH; jal→JAL; jalr→JALR1; lui/auipc→UPPER; other→TRAP or FETCH per parameter.
  - MEMADR: ALUSrcA=10, ALUSrcB=01. lw→MEMREAD; sw→MEMWRITE.
  - MEMREAD: mem_req, AdrSrc=1. Moves to MEMWB on mem_ready.
  - MEMWB: ResultSrc=01, RegWrite. Next: FETCH.
  - MEMWRITE: mem_req, AdrSrc=1, MemWrite on mem_ready. Moves to FETCH on mem_ready.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite. Next: FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate. Next: ALUWB.
  - JALR1: ALUSrcA=10, ALUSrcB=01. Next: JALR2.
  - JALR2: PCUpdate with ResultSrc=00, plus ALUSrcA=01, ALUSrcB=10. Next: ALUWB.
  - UPPER: ALUSrcA = op[5] ? 11 : 01, ALUSrcB=01. Next: ALUWB.
  - TRAP: illegal=1, all enables 0. Holds until reset.

## Timing
- Reset (rst_n low) takes effect immediately, asynchronously: state=FETCH, illegal=0. While rst_n is low, all enables (IRWrite, PCUpdate, RegWrite, MemWrite, Branch, mem_req) are forced to 0. Selects show FETCH values.
- Cycles per instruction with zero wait states (mem_ready held 1): branch 3; sw, R, I, jal, lui, auipc 4; lw, jalr 5. Each memory-state cycle with mem_ready=0 adds one cycle.
- mem_req stays high, with address select stable, until mem_ready. Write enables pulse for exactly one cycle.
- A reset during MEMREAD or MEMWRITE abandons the access. No write enable is asserted afterwards; the next access is the FETCH after rst_n deasserts.

## Structure
- Package `mc_ctrl_pkg`: state enum `mc_state_t` (4-bit, 15 states); opcode constants; ALUSrcA/B, ResultSrc, ImmSrc and ALUOp encoding constants (shared with the datapath and the ALU decoder).
- One natural sub-module: `imm_srcdec`, the combinational op→ImmSrc decoder.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1 → state_o=FETCH, all enables 0; first posedge after release asserts IRWrite and PCUpdate.
- lw, mem_ready always 1 → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with ResultSrc=01 in cycle 5.
- sw with mem_ready low for 2 cycles in MEMWRITE → MemWrite=0 for 2 cycles, then exactly one MemWrite pulse; 6 cycles total.
- jalr → JALR2 asserts PCUpdate with ResultSrc=00; ALUWB RegWrite follows; 5 cycles total.
- op=7'b1111111: with TRAP_ON_ILLEGAL=1 → TRAP, illegal=1 and held for 10 cycles. With TRAP_ON_ILLEGAL=0 → FETCH after DECODE, illegal stays 0.
- rst_n pulsed low mid-MEMREAD → immediate FETCH, no RegWrite ever asserted for that lw.
